seq_frame_tx: RTL and testbench

SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

---
 rtl/seq_frame_pkg.sv | 22 ++
 rtl/seq_frame_tx_if.sv | 15 +
 rtl/piso_shift_reg.sv | 22 ++
 rtl/seq_frame_tx.sv | 108 ++++++++++
 tb/tb_seq_frame_tx.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/seq_frame_pkg.sv
// rtl/seq_frame_pkg.sv - shared constants, state encoding and counter sizing for seq_frame_tx
package seq_frame_pkg;

  localparam int PRE_LEN = 4;
  localparam int PRE_IDX_W = 2;
  localparam logic [PRE_LEN-1:0] PREAMBLE = 4'b1010;
  localparam int GUARD_CNT_W = 3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_PREAMBLE = 2'd1;
  localparam state_t ST_PAYLOAD  = 2'd2;
  localparam state_t ST_GUARD    = 2'd3;

  // One counter serves preamble, payload and guard, so it must hold the largest of the three.
  function automatic int cnt_width(input int data_w);
    int w;
    w = $clog2(data_w + 1);
    return (w > GUARD_CNT_W) ? w : GUARD_CNT_W;
  endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// rtl/seq_frame_tx_if.sv - frame request and serial output bundle for seq_frame_tx
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
) ();
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic [3:0]        len;
  logic              out;
  logic              out_valid;
  logic              busy;
  logic              done;

  modport master (output start, data_in, len, input out, out_valid, busy, done);
  modport slave  (input start, data_in, len, output out, out_valid, busy, done);
endinterface

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-load, MSB-first shift register holding the payload
module piso_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);
  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
    end
  end

  assign msb = sr[W-1];
endmodule

// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - serial frame transmitter: preamble, MSB-first payload, idle guard, done pulse
module seq_frame_tx
  import seq_frame_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int GUARD_LEN = 2
) (
  input logic           clk,
  input logic           rst,
  seq_frame_tx_if.slave bus
);
  localparam int CNT_W = cnt_width(DATA_W);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  len_clamped;
  logic [DATA_W-1:0] load_data;
  logic [PRE_IDX_W-1:0] pre_idx;
  logic              accept;
  logic              sr_shift;
  logic              sr_msb;

  always_comb begin
    accept = (state == ST_IDLE) && bus.start && (bus.len != 4'd0);
    if (int'(bus.len) > DATA_W) begin
      len_clamped = CNT_W'(DATA_W);
    end else begin
      len_clamped = CNT_W'(bus.len);
    end
    // Left-align the payload so bit L-1 sits at the shift register MSB.
    load_data = bus.data_in << (DATA_W - int'(len_clamped));
    pre_idx   = PRE_IDX_W'(cnt - CNT_W'(1));
    sr_shift  = ((state == ST_PREAMBLE) && (cnt == '0)) ||
                ((state == ST_PAYLOAD) && (cnt != '0));
  end

  piso_shift_reg #(.W(DATA_W)) u_piso (
    .clk   (clk),
    .load  (accept),
    .shift (sr_shift),
    .din   (load_data),
    .msb   (sr_msb)
  );

  // Outputs are registered; state names the phase the outputs currently show.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      len_q         <= '0;
      bus.out       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state         <= ST_PREAMBLE;
            cnt           <= CNT_W'(PRE_LEN - 1);
            len_q         <= len_clamped;
            bus.out       <= PREAMBLE[PRE_LEN-1];
            bus.out_valid <= 1'b1;
            bus.busy      <= 1'b1;
          end
        end
        ST_PREAMBLE: begin
          if (cnt != '0) begin
            cnt     <= cnt - CNT_W'(1);
            bus.out <= PREAMBLE[pre_idx];
          end else begin
            state   <= ST_PAYLOAD;
            cnt     <= len_q - CNT_W'(1);
            bus.out <= sr_msb;
          end
        end
        ST_PAYLOAD: begin
          if (cnt != '0) begin
            cnt     <= cnt - CNT_W'(1);
            bus.out <= sr_msb;
          end else begin
            state         <= ST_GUARD;
            cnt           <= CNT_W'(GUARD_LEN - 1);
            bus.out       <= 1'b0;
            bus.out_valid <= 1'b0;
          end
        end
        ST_GUARD: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: begin
          state         <= ST_IDLE;
          bus.out       <= 1'b0;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_frame_tx.sv
// tb/tb_seq_frame_tx.sv - directed self-checking bench for seq_frame_tx
module tb_seq_frame_tx;
  logic clk;
  logic rst;
  int   tests;
  int   failed;
  int   hits;
  int   vcnt;
  int   h0;
  logic [3:0] win;

  seq_frame_tx_if #(.DATA_W(8)) bus ();

  seq_frame_tx #(.DATA_W(8), .GUARD_LEN(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overlapping 1010 detector on the valid bit stream, window cleared on gaps.
  initial begin
    hits = 0;
    vcnt = 0;
    win  = 4'b0;
  end
  always @(posedge clk) begin
    #1;
    if (bus.out_valid) begin
      win  = {win[2:0], bus.out};
      vcnt = vcnt + 1;
      if (vcnt >= 4 && win == 4'b1010) hits = hits + 1;
    end else begin
      vcnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.out, bus.out_valid, bus.busy, bus.done};
  endfunction

  // Walks one frame from cycle 1 through the done cycle; caller drives start in cycle 0.
  task automatic frame_check(input string name, input logic [31:0] stream, input int nbits,
                             input bit clear_start, input int inject);
    int total;
    logic [3:0] exp;
    total = nbits + 2 + 1;
    for (int c = 1; c <= total; c++) begin
      step();
      if (c <= nbits)          exp = {stream[nbits-c], 3'b110};
      else if (c <= nbits + 2) exp = 4'b0010;
      else                     exp = 4'b0001;
      check($sformatf("%s_c%0d", name, c), 32'(outs()), 32'(exp));
      if (c == 1 && clear_start) bus.start = 1'b0;
      if (inject > 0 && c == inject) begin
        bus.start   = 1'b1;
        bus.data_in = 8'h3C;
        bus.len     = 4'd4;
      end
      if (inject > 0 && c == inject + 1) bus.start = 1'b0;
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = 8'h00;
    bus.len     = 4'd0;
    @(negedge clk);
    step();
    check("reset_state", 32'(outs()), 32'h0);

    bus.start = 1'b1;
    bus.len   = 4'd8;
    step();
    check("rst_over_start", 32'(outs()), 32'h0);
    rst = 1'b0;
    bus.start = 1'b0;
    step();
    check("idle_after_reset", 32'(outs()), 32'h0);

    bus.data_in = 8'hA5; bus.len = 4'd8; bus.start = 1'b1;
    frame_check("a5_len8", 32'hAA5, 12, 1'b1, 0);

    bus.data_in = 8'hFF; bus.len = 4'd3; bus.start = 1'b1;
    frame_check("ff_len3", 32'h57, 7, 1'b1, 0);

    bus.data_in = 8'hFF; bus.len = 4'd0; bus.start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("len0_c%0d", i), 32'({bus.out_valid, bus.busy, bus.done}), 32'h0);
    end
    bus.start = 1'b0;

    bus.data_in = 8'hA5; bus.len = 4'd12; bus.start = 1'b1;
    frame_check("len12_clamp", 32'hAA5, 12, 1'b1, 0);

    bus.data_in = 8'h0A; bus.len = 4'd4; bus.start = 1'b1;
    for (int f = 0; f < 3; f++) begin
      h0 = hits;
      frame_check($sformatf("b2b_f%0d", f), 32'hAA, 8, 1'b0, 0);
      check($sformatf("detect_f%0d", f), 32'(hits > h0), 32'h1);
    end
    bus.start = 1'b0;
    step();
    check("b2b_idle", 32'(outs()), 32'h0);

    bus.data_in = 8'hA5; bus.len = 4'd8; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 2; c <= 6; c++) step();
    check("abort_c6", 32'(outs()), 32'h6);
    rst = 1'b1;
    step();
    check("abort_c7", 32'(outs()), 32'h0);
    rst = 1'b0;
    step();
    check("abort_c8", 32'(outs()), 32'h0);
    step();
    check("abort_c9", 32'(outs()), 32'h0);
    bus.start = 1'b1;
    frame_check("after_abort", 32'hAA5, 12, 1'b1, 0);

    bus.data_in = 8'hA5; bus.len = 4'd8; bus.start = 1'b1;
    frame_check("mid_start", 32'hAA5, 12, 1'b1, 7);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("no_second_%0d", i), 32'(outs()), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
